inst_encoder: RTL
=================

# inst_encoder

Sequential MIPS instruction encoder and program loader: the inverse of the instruction decoder. It accepts decoded instruction records (the shared `INST_*` operation code plus register, shift, immediate and jump-target fields) over a valid/ready handshake. Each record is packed into a 32-bit machine word using the shared `OPCODE_*`/`FUNCT_*` encodings from `defines.v`, and the word is written into instruction memory at consecutive word addresses. It sits between the testbench/boot program source and the instruction RAM, and stops loading at `HLT` or when memory is full.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.
- `BASE_ADDR`, 0, first word address written after reset or `start`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle pulse: rewind to `BASE_ADDR`, clear `done`/`err`, enter RUN.
- `in_valid`  in  1  record present.
- `in_ready`  out  1  encoder can accept a record this cycle.
- `in_inst`  in  6  `INST_*` operation code.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register/shift fields.
- `in_imm`  in  16  immediate / branch offset.
- `in_target`  in  26  J/JAL word target.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  words written since the last `start` or reset.
- `done`  out  1  `HLT` has been written.
- `err`  out  1  sticky: memory overflow, unknown `in_inst`, or (with the check macro) non-canonical fields.

## Operation
- States: IDLE, RUN, DONE, FULL. Reset enters IDLE. `start` moves any state to RUN. `start` has priority over a simultaneous accept, and that accepted record is discarded.
- `in_ready` = 1 only in RUN. A record is accepted when `in_valid && in_ready`.
- Encoding:
  - ADDU/SUBU/SLT: `{SPECIAL, rs, rt, rd, 5'b0, funct}`.
  - JR: `{SPECIAL, rs, 15'b0, FUNCT_JR}`.
  - ORI/LW/SW/BEQ/ADDI/ADDIU: `{opcode, rs, rt, imm}`.
  - LUI: `{OPCODE_LUI, 5'b0, rt, imm}`.
  - J/JAL: `{opcode, target}`.
  - HLT: `{OPCODE_HLT, 26'b0}`.
  - NOP: 32'h0.
  - Any other code: 32'h0, and `err` is set.
- The address register starts at `BASE_ADDR` and increments by 1 per write. `count` increments by 1 per write.
- Accepted HLT: after its write, the state moves to DONE and `done` = 1.
- Overflow: if the write lands at address 2^ADDR_W-1 and the record is not HLT, the state moves to FULL and `err` = 1. No wrap-around write ever occurs. If the last word is HLT, the state moves to DONE with `err` = 0.
- In DONE and FULL, `in_ready` = 0 and input is ignored until `start`.

## Timing
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` BASE_ADDR, `mem_wdata` 0, `count` 0, `done` 0, `err` 0, state IDLE.
- Latency: a record accepted in cycle N appears as `mem_we`=1 with its word in cycle N+1. `mem_we` is a single-cycle pulse per record.
- Throughput: one record per cycle while in RUN. Back-to-back accepts produce consecutive addresses with no bubbles.
- Accepting HLT drops `in_ready` in cycle N+1. `done` rises in cycle N+1, together with the HLT write.
- `start` in cycle N: `in_ready`=1 in N+1, with `mem_addr`=BASE_ADDR and `count`=0.
- `rst_n` low mid-load: the pending write is cancelled, so `mem_we`=0 in the next cycle, and all outputs return to their reset values.

## Configuration
- `ENC_FIELD_CHECK_EN` defined:
  - A record is non-canonical if it is R-type with `shamt`≠0, JR with `rt`≠0 or `rd`≠0, or LUI with `rs`≠0.
  - A non-canonical record is written as 32'h0 (what the decoder would execute as NOP) and sets `err`. The address still advances.
- `ENC_FIELD_CHECK_EN` undefined: the offending fields are silently forced to zero per the encodings above, and `err` is unaffected by field content.

## Test plan
- Reset, `start`, ADDU rd=3 rs=1 rt=2 -> `mem_we` next cycle, addr 0, data 32'h00221821, `count`=1.
- Back-to-back ORI rt=1 rs=0 imm=16'h1234, LUI rt=2 imm=16'h8000, BEQ rs=1 rt=2 imm=16'hFFFF, SW rt=5 rs=6 imm=4 -> words 32'h34011234, 32'h3C028000, 32'h1022FFFF, 32'hACC50004 at addrs 0–3, no bubbles.
- J target=26'h0000C00 then HLT -> 32'h08000C00 at addr 0. HLT word at addr 1, `done`=1, `in_ready`=0. A further `in_valid` is ignored.
- ADDR_W=2: five non-HLT records -> four writes (addrs 0–3), FULL, `err`=1, fifth record never accepted. Then `start` -> `err`=0 and addr 0.
- With `ENC_FIELD_CHECK_EN`: LUI rs=4 -> data 32'h0, `err`=1. Without the macro, the same record -> `{OPCODE_LUI, 5'b0, rt, imm}`, `err`=0.
- `rst_n` low in the cycle after an accept -> no `mem_we`, all outputs at their reset values.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: sequential MIPS instruction encoder and program loader.
// Accepts decoded instruction records over valid/ready, packs each into a
// 32-bit machine word and writes it to consecutive instruction-memory words.
// Loading stops on HLT (DONE) or when the last memory word has been used (FULL).
// Optional build macro: ENC_FIELD_CHECK_EN. When it is defined, non-canonical
// records are written as 32'h0 and raise err. When it is undefined, the
// offending fields are silently dropped.
module inst_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_inst,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  // Shared operation codes of the decoded instruction record
  localparam logic [5:0] INST_NOP   = 6'd0;
  localparam logic [5:0] INST_ADDU  = 6'd1;
  localparam logic [5:0] INST_SUBU  = 6'd2;
  localparam logic [5:0] INST_SLT   = 6'd3;
  localparam logic [5:0] INST_JR    = 6'd4;
  localparam logic [5:0] INST_ORI   = 6'd5;
  localparam logic [5:0] INST_LW    = 6'd6;
  localparam logic [5:0] INST_SW    = 6'd7;
  localparam logic [5:0] INST_BEQ   = 6'd8;
  localparam logic [5:0] INST_ADDI  = 6'd9;
  localparam logic [5:0] INST_ADDIU = 6'd10;
  localparam logic [5:0] INST_LUI   = 6'd11;
  localparam logic [5:0] INST_J     = 6'd12;
  localparam logic [5:0] INST_JAL   = 6'd13;
  localparam logic [5:0] INST_HLT   = 6'd14;

  // MIPS primary opcodes and SPECIAL function codes
  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_J       = 6'h02;
  localparam logic [5:0] OPCODE_JAL     = 6'h03;
  localparam logic [5:0] OPCODE_BEQ     = 6'h04;
  localparam logic [5:0] OPCODE_ADDI    = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
  localparam logic [5:0] OPCODE_ORI     = 6'h0D;
  localparam logic [5:0] OPCODE_LUI     = 6'h0F;
  localparam logic [5:0] OPCODE_LW      = 6'h23;
  localparam logic [5:0] OPCODE_SW      = 6'h2B;
  localparam logic [5:0] OPCODE_HLT     = 6'h3F;
  localparam logic [5:0] FUNCT_JR       = 6'h08;
  localparam logic [5:0] FUNCT_ADDU     = 6'h21;
  localparam logic [5:0] FUNCT_SUBU     = 6'h23;
  localparam logic [5:0] FUNCT_SLT      = 6'h2A;

  // Loader states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [ADDR_W-1:0] L_BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] L_LAST     = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] L_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   L_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

`ifdef ENC_FIELD_CHECK_EN
  localparam logic L_CHECK_EN = 1'b1;
`else
  localparam logic L_CHECK_EN = 1'b0;
`endif

  // Pack a record into its machine word; fields outside the format are dropped
  function automatic logic [31:0] f_encode(
    input logic [5:0]  inst,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [31:0] w;
    w = 32'h0;
    case (inst)
      INST_ADDU:  w = {OPCODE_SPECIAL, rs, rt, rd, 5'b0, FUNCT_ADDU};
      INST_SUBU:  w = {OPCODE_SPECIAL, rs, rt, rd, 5'b0, FUNCT_SUBU};
      INST_SLT:   w = {OPCODE_SPECIAL, rs, rt, rd, 5'b0, FUNCT_SLT};
      INST_JR:    w = {OPCODE_SPECIAL, rs, 15'b0, FUNCT_JR};
      INST_ORI:   w = {OPCODE_ORI, rs, rt, imm};
      INST_LW:    w = {OPCODE_LW, rs, rt, imm};
      INST_SW:    w = {OPCODE_SW, rs, rt, imm};
      INST_BEQ:   w = {OPCODE_BEQ, rs, rt, imm};
      INST_ADDI:  w = {OPCODE_ADDI, rs, rt, imm};
      INST_ADDIU: w = {OPCODE_ADDIU, rs, rt, imm};
      INST_LUI:   w = {OPCODE_LUI, 5'b0, rt, imm};
      INST_J:     w = {OPCODE_J, tgt};
      INST_JAL:   w = {OPCODE_JAL, tgt};
      INST_HLT:   w = {OPCODE_HLT, 26'b0};
      INST_NOP:   w = 32'h0;
      default:    w = 32'h0;
    endcase
    return w;
  endfunction

  // True when the operation code is not one the encoder knows
  function automatic logic f_unknown(input logic [5:0] inst);
    return (inst > INST_HLT);
  endfunction

  // True when a record carries field bits its format has no room for
  function automatic logic f_noncanon(
    input logic [5:0] inst,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] shamt
  );
    logic bad;
    bad = 1'b0;
    case (inst)
      INST_ADDU, INST_SUBU, INST_SLT: bad = (shamt != 5'd0);
      INST_JR:                        bad = (rt != 5'd0) || (rd != 5'd0);
      INST_LUI:                       bad = (rs != 5'd0);
      default:                        bad = 1'b0;
    endcase
    return bad;
  endfunction

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_err;

  logic        w_accept;
  logic        w_is_hlt;
  logic        w_last;
  logic        w_reject;
  logic        w_rec_err;
  logic [31:0] w_word;

  assign w_accept  = in_valid && (r_state == S_RUN);
  assign w_is_hlt  = (in_inst == INST_HLT);
  assign w_last    = (r_next_addr == L_LAST);
  assign w_reject  = L_CHECK_EN && f_noncanon(in_inst, in_rs, in_rt, in_rd, in_shamt);
  assign w_rec_err = f_unknown(in_inst) || w_reject;
  assign w_word    = w_reject ? 32'h0
                              : f_encode(in_inst, in_rs, in_rt, in_rd, in_imm, in_target);

  // Sequencer: reset, restart on start, and one memory write per accepted record
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_next_addr <= L_BASE;
      r_mem_addr  <= L_BASE;
      r_mem_wdata <= 32'h0;
      r_mem_we    <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (start) begin
      // a record offered alongside start is dropped on purpose
      r_state     <= S_RUN;
      r_next_addr <= L_BASE;
      r_mem_addr  <= L_BASE;
      r_mem_we    <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_mem_we    <= 1'b1;
      r_mem_addr  <= r_next_addr;
      r_mem_wdata <= w_word;
      r_next_addr <= r_next_addr + L_ADDR_ONE;
      r_count     <= r_count + L_CNT_ONE;
      if (w_is_hlt) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
        r_err   <= r_err | w_rec_err;
      end else if (w_last) begin
        // the last word is used by a non-HLT record: stop before any wrap
        r_state <= S_FULL;
        r_err   <= 1'b1;
      end else begin
        r_err   <= r_err | w_rec_err;
      end
    end else begin
      r_mem_we <= 1'b0;
    end
  end

  assign in_ready  = (r_state == S_RUN);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign done      = r_done;
  assign err       = r_err;

endmodule
